processador_multiciclo_param: RTL

PROCESSADOR_MULTICICLO_PARAM -- requirements
Module: processador_multiciclo_param

---
 rtl/processador_multiciclo_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/processador_multiciclo_param.sv
// processador_multiciclo_param: multicycle processor with eight general registers,
// a shared internal bus and a four-step (T0..T3) sequencer.
// mv/mvi finish in T1; ALU ops use T1 (A<=Rx), T2 (G<=A op Ry) and T3 (Rx<=G).
module processador_multiciclo_param #(
  parameter int DATA_W     = 16,   // datapath and register width, 4..32
  parameter bit SIGNED_SLT = 1'b1  // 1: slt is two's-complement, 0: unsigned
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic [1:0]        Tstep,
  output logic [DATA_W-1:0] Rx_data,
  output logic [DATA_W-1:0] Ry_data
);

  typedef enum logic [1:0] {T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T3 = 2'b11} step_t;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_SLT = 3'b110,
    OP_SLL = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {SEL_NONE, SEL_DIN, SEL_RX, SEL_RY, SEL_G} bus_sel_t;

  step_t             step_q, step_d;
  logic [8:0]        ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] a_q, g_q, alu_y;
  logic [8:0]        din_instr;
  bus_sel_t          bus_sel;
  logic              ir_en, a_en, g_en, rx_wr;
  logic              lt;

  opcode_t    opcode;
  logic [2:0] rx_idx, ry_idx;

  assign opcode = opcode_t'(ir[8:6]);
  assign rx_idx = ir[5:3];
  assign ry_idx = ir[2:0];

  // Instruction word taken from DIN[8:0]; with DATA_W < 9 the missing upper
  // instruction bits read as 0, so only the opcodes that fit are reachable.
  if (DATA_W >= 9) begin : g_instr_wide
    assign din_instr = DIN[8:0];
  end else begin : g_instr_narrow
    assign din_instr = {{(9 - DATA_W){1'b0}}, DIN};
  end

  // Sequencer decode: next step, bus source, load enables and Done.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case can leave a signal unassigned and infer a latch.
    step_d  = step_q;
    bus_sel = SEL_NONE;
    ir_en   = 1'b0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    rx_wr   = 1'b0;
    Done    = 1'b0;
    case (step_q)
      T0: begin
        if (Run) begin
          ir_en  = 1'b1;
          step_d = T1;
        end
      end
      T1: begin
        if (opcode == OP_MV || opcode == OP_MVI) begin
          bus_sel = (opcode == OP_MV) ? SEL_RY : SEL_DIN;
          rx_wr   = 1'b1;
          Done    = 1'b1;
          step_d  = T0;
        end else begin
          bus_sel = SEL_RX;
          a_en    = 1'b1;
          step_d  = T2;
        end
      end
      T2: begin
        bus_sel = SEL_RY;
        g_en    = 1'b1;
        step_d  = T3;
      end
      T3: begin
        bus_sel = SEL_G;
        rx_wr   = 1'b1;
        Done    = 1'b1;
        step_d  = T0;
      end
      default: step_d = T0;
    endcase
  end

  // Bus multiplexer: a single source at a time, zero when nothing drives it.
  always_comb begin
    BusWires = '0;
    case (bus_sel)
      SEL_DIN: BusWires = DIN;
      SEL_RX:  BusWires = regs[rx_idx];
      SEL_RY:  BusWires = regs[ry_idx];
      SEL_G:   BusWires = g_q;
      default: BusWires = '0;
    endcase
  end

  // ALU: A is the first operand, the bus (Ry in T2) the second; results wrap.
  always_comb begin
    alu_y = '0;
    if (SIGNED_SLT) lt = $signed(a_q) < $signed(BusWires);
    else            lt = a_q < BusWires;
    case (opcode)
      OP_ADD: alu_y = a_q + BusWires;
      OP_SUB: alu_y = a_q - BusWires;
      OP_AND: alu_y = a_q & BusWires;
      OP_OR:  alu_y = a_q | BusWires;
      OP_SLT: alu_y = {{(DATA_W - 1){1'b0}}, lt};
      OP_SLL: alu_y = (32'(BusWires) >= 32'(DATA_W)) ? '0 : (a_q << BusWires);
      default: alu_y = '0;
    endcase
  end

  // Step counter, IR and the A/G operand registers.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (Reset) begin
      step_q <= T0;
      ir     <= '0;
      a_q    <= '0;
      g_q    <= '0;
    end else begin
      step_q <= step_d;
      if (ir_en) ir  <= din_instr;
      if (a_en)  a_q <= BusWires;
      if (g_en)  g_q <= alu_y;
    end
  end

  // Register file R0..R7: Rx is written from the bus on the final step.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: the register file is reset explicitly because an aborted instruction
    // must leave all architected state at zero; this keeps it in flip-flops.
    if (Reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (rx_wr) begin
      regs[rx_idx] <= BusWires;
    end
  end

  assign Tstep   = step_q;
  assign Rx_data = regs[rx_idx];
  assign Ry_data = regs[ry_idx];

endmodule
